// File: rtl/pad_scan.sv
// Host-side Mega Drive/Genesis 3/6-button pad scanner: walks TH through the
// 8-phase read sequence, samples PAD_D and commits decoded buttons once per scan.
module pad_scan #(
  parameter int unsigned SETTLE   = 16,
  parameter int unsigned IDLE_GAP = 16384
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       J3BUT,
  input  logic [5:0] PAD_D,
  output logic       PAD_TH,
  output logic       PAD_TR,
  output logic       P_UP,
  output logic       P_DOWN,
  output logic       P_LEFT,
  output logic       P_RIGHT,
  output logic       P_A,
  output logic       P_B,
  output logic       P_C,
  output logic       P_START,
  output logic       P_MODE,
  output logic       P_X,
  output logic       P_Y,
  output logic       P_Z,
  output logic       PRESENT,
  output logic       SIX_BTN,
  output logic       VALID
);

  localparam int unsigned GAP_W  = $clog2(IDLE_GAP + 1);
  localparam int unsigned WAIT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_PHASE, S_COMMIT} state_t;

  state_t            state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        idx;
  logic              j3_lat;
  logic [5:0]        sync_q1;
  logic [5:0]        sync_q2;

  // Only the shadow bits that feed the decode are kept.
  logic [5:0]        sh0;
  logic [5:2]        sh1;
  logic [3:0]        sh5;
  logic [3:0]        sh6;
  logic [3:0]        sh7;

  logic              pad_th;
  logic              pad_tr;
  logic              present_q;
  logic              six_q;
  logic              valid_q;
  // {MODE, X, Y, Z, START, A, B, C, UP, DOWN, LEFT, RIGHT}
  logic [11:0]       btn_q;

  logic              last_phase_c;
  logic              dec_present_c;
  logic              dec_six_c;
  logic [11:0]       dec_btn_c;

  assign last_phase_c = j3_lat ? (idx == 3'd1) : (idx == 3'd7);

  // Decode of the shadow registers; everything forced to 0 with no pad present.
  always_comb begin
    dec_present_c = (sh1[3:2] == 2'b00);
    dec_six_c     = dec_present_c & ~j3_lat & (sh5 == 4'b0000) & (sh7 == 4'b1111);
    dec_btn_c     = '0;
    if (dec_present_c) begin
      dec_btn_c[7:0] = {~sh1[5], ~sh1[4], ~sh0[4], ~sh0[5],
                        ~sh0[0], ~sh0[1], ~sh0[2], ~sh0[3]};
      if (dec_six_c) begin
        dec_btn_c[11:8] = ~sh6;
      end
    end
  end

  always_ff @(posedge CLK) begin
    sync_q1 <= PAD_D;
    sync_q2 <= sync_q1;
    if (RESET) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      wait_cnt  <= '0;
      idx       <= '0;
      j3_lat    <= 1'b0;
      sh0       <= '0;
      sh1       <= '0;
      sh5       <= '0;
      sh6       <= '0;
      sh7       <= '0;
      pad_th    <= 1'b1;
      pad_tr    <= 1'b1;
      present_q <= 1'b0;
      six_q     <= 1'b0;
      valid_q   <= 1'b0;
      btn_q     <= '0;
    end else begin
      pad_tr  <= 1'b1;
      valid_q <= 1'b0;
      if (CE) begin
        case (state)
          S_IDLE: begin
            if (gap_cnt == GAP_W'(IDLE_GAP - 1)) begin
              gap_cnt  <= '0;
              wait_cnt <= '0;
              idx      <= '0;
              j3_lat   <= J3BUT;
              pad_th   <= 1'b1;
              state    <= S_PHASE;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          S_PHASE: begin
            if (wait_cnt == WAIT_W'(SETTLE - 1)) begin
              wait_cnt <= '0;
              case (idx)
                3'd0:    sh0 <= sync_q2;
                3'd1:    sh1 <= sync_q2[5:2];
                3'd5:    sh5 <= sync_q2[3:0];
                3'd6:    sh6 <= sync_q2[3:0];
                3'd7:    sh7 <= sync_q2[3:0];
                default: ;
              endcase
              if (last_phase_c) begin
                pad_th <= 1'b1;
                state  <= S_COMMIT;
              end else begin
                // Next phase is idx+1, whose TH level is ~(idx+1)[0] == idx[0].
                idx    <= idx + 3'd1;
                pad_th <= idx[0];
              end
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
          S_COMMIT: begin
            present_q <= dec_present_c;
            six_q     <= dec_six_c;
            btn_q     <= dec_btn_c;
            valid_q   <= 1'b1;
            pad_th    <= 1'b1;
            gap_cnt   <= '0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign PAD_TH  = pad_th;
  assign PAD_TR  = pad_tr;
  assign P_MODE  = btn_q[11];
  assign P_X     = btn_q[10];
  assign P_Y     = btn_q[9];
  assign P_Z     = btn_q[8];
  assign P_START = btn_q[7];
  assign P_A     = btn_q[6];
  assign P_B     = btn_q[5];
  assign P_C     = btn_q[4];
  assign P_UP    = btn_q[3];
  assign P_DOWN  = btn_q[2];
  assign P_LEFT  = btn_q[1];
  assign P_RIGHT = btn_q[0];
  assign PRESENT = present_q;
  assign SIX_BTN = six_q;
  assign VALID   = valid_q;

endmodule
